// File: rtl/sm_dmem_arbiter.sv
// Arbiter sharing a single-port data memory between the CPU load/store port and a debug/DMA master.
// Optional build macro SM_DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority on ties; otherwise ties alternate.
module sm_dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RWAIT = 2'd2
    } state_t;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DBG = 1'b1;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          sel_r;
    logic          we_r;
    logic          last_r;
    logic          cpu_rvalid_r;
    logic          dbg_rvalid_r;
    logic [DW-1:0] cpu_rdata_r;
    logic [DW-1:0] dbg_rdata_r;
    logic          any_req_s;
    logic          tie_dbg_s;
    logic          win_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdata_s;
    logic          issue_nxt_s;
    logic          rvalid_nxt_s;

    // Winner selection: the sole requester, otherwise the tie-break rule.
    always_comb begin
        any_req_s = cpu_req | dbg_req;
`ifdef SM_DMEM_ARB_CPU_PRIO_EN
        tie_dbg_s = 1'b0;
`else
        tie_dbg_s = (last_r == SEL_CPU);
`endif
        win_s       = dbg_req & (~cpu_req | tie_dbg_s);
        win_we_s    = (win_s == SEL_DBG) ? dbg_we    : cpu_we;
        win_addr_s  = (win_s == SEL_DBG) ? dbg_addr  : cpu_addr;
        win_wdata_s = (win_s == SEL_DBG) ? dbg_wdata : cpu_wdata;
    end

    // Next-state logic; outputs are registered from the upcoming state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) state_nxt_s = ST_ISSUE;
                else           state_nxt_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (we_r) state_nxt_s = ST_IDLE;
                else      state_nxt_s = ST_RWAIT;
            end
            ST_RWAIT: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
        issue_nxt_s  = (state_r == ST_IDLE) && any_req_s;
        rvalid_nxt_s = (state_r == ST_ISSUE) && !we_r;
    end

    // State register, holding registers and the round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sel_r   <= SEL_CPU;
            we_r    <= 1'b0;
            last_r  <= SEL_DBG;
        end else begin
            state_r <= state_nxt_s;
            if (issue_nxt_s) begin
                sel_r <= win_s;
                we_r  <= win_we_s;
            end
            if (state_r == ST_ISSUE) begin
                last_r <= sel_r;
            end
        end
    end

    // Memory strobes and grant/valid pulses, registered one cycle ahead of use.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= {AW{1'b0}};
            mem_wdata    <= {DW{1'b0}};
            cpu_gnt      <= 1'b0;
            dbg_gnt      <= 1'b0;
            cpu_rvalid_r <= 1'b0;
            dbg_rvalid_r <= 1'b0;
        end else begin
            mem_en       <= issue_nxt_s;
            mem_we       <= issue_nxt_s & win_we_s;
            mem_addr     <= issue_nxt_s ? win_addr_s  : {AW{1'b0}};
            mem_wdata    <= issue_nxt_s ? win_wdata_s : {DW{1'b0}};
            cpu_gnt      <= issue_nxt_s & (win_s == SEL_CPU);
            dbg_gnt      <= issue_nxt_s & (win_s == SEL_DBG);
            cpu_rvalid_r <= rvalid_nxt_s & (sel_r == SEL_CPU);
            dbg_rvalid_r <= rvalid_nxt_s & (sel_r == SEL_DBG);
        end
    end

    // Read-data capture at the end of RWAIT; held until the next read for that master.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_r <= {DW{1'b0}};
            dbg_rdata_r <= {DW{1'b0}};
        end else begin
            if (cpu_rvalid_r) cpu_rdata_r <= mem_rdata;
            if (dbg_rvalid_r) dbg_rdata_r <= mem_rdata;
        end
    end

    // A reset raised during RWAIT suppresses the pending valid; read data bypasses during the pulse.
    assign cpu_rvalid = cpu_rvalid_r & ~rst;
    assign dbg_rvalid = dbg_rvalid_r & ~rst;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_r;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_r;

endmodule
